demux: RTL and testbench
========================

# demux

Registered 1-to-N demultiplexer with valid/ready handshaking: the write-side counterpart of the datapath `MUX`. It accepts one 32-bit word per cycle plus a select code and delivers the word to exactly one of up to four output channels. Each output channel has a one-entry holding register, so a slow consumer on one channel does not stall traffic to the other channels. It sits between a single producer, such as the write-back/result bus, and several independent consumers.

## Interface
- `width`, default 1: select width. The only legal values are 1 (two channels, 0..1) and 2 (four channels, 0..3).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  producer offers `data_i`/`s` this cycle.
- `ready_o`  out  1  block accepts the offered word this cycle.
- `s`  in  `width`  destination channel for the offered word.
- `data_i`  in  32  offered word.
- `valid_o`  out  4  per-channel "holding register full".
- `ready_i`  in  4  per-channel consumer ready.
- `d0_o`, `d1_o`, `d2_o`, `d3_o`  out  32 each  per-channel holding register contents.
- `count_o`  out  16  number of words accepted since reset; wraps modulo 2^16.

## Operation
- Each channel k has a full flag `valid_o[k]` and a data register `dk_o`.
- `ready_o = !valid_o[s] || ready_i[s]`. This is combinational in `s` and `ready_i`. The producer must not make `valid_i` depend on `ready_o`.
- Input transfer happens when `valid_i && ready_o`.
  - The rising edge loads `d[s]_o <= data_i` and sets `valid_o[s] <= 1`.
  - `count_o` increments on the same edge.
- Output transfer on channel k happens when `valid_o[k] && ready_i[k]`. On that edge `valid_o[k]` clears, unless an input transfer targets k on the same edge, in which case it stays 1 and `dk_o` takes the new word.
- Holding registers change only on an input transfer. When a channel empties, `dk_o` keeps its stale value.
- Invalid select handling when `width==1`:
  - Channels 2 and 3 are never written.
  - `valid_o[3:2]` stays 0 and `d2_o`/`d3_o` stay 0.
  - `ready_i[3:2]` is ignored.
- Transfers to different channels are independent. Any subset of channels may drain in the same cycle that another channel is loaded.
- `ready_i[k]` asserted while `valid_o[k]==0` has no effect.

## Timing
- Reset values (asynchronous, immediate):
  - `valid_o = 4'b0000`, `d0_o..d3_o = 0`, `count_o = 0`.
  - `ready_o` is then 1 for any `s`.
- Latency: a word accepted at edge N is visible on `dk_o` with `valid_o[k]=1` after edge N.
- Throughput: one word per cycle into the same channel when its consumer holds `ready_i[k]=1` (pass-through case).
- Full channel with the consumer not ready: `ready_o=0` while `s` points at it. The producer holds `valid_i`/`data_i`/`s` stable until accepted. The block never drops or overwrites an unconsumed word.
- `count_o` wraps from 16'hFFFF to 16'h0000 on the next accepted word, with no flag.
- Reset mid-operation: all held words are discarded, flags clear and `count_o` returns to 0 regardless of pending handshakes. The first edge after `rst` deasserts behaves as a fresh start.

## Structure
- A shared package holds:
  - `DATA_W = 32`, `NCH = 4`, `CNT_W = 16`;
  - a channel-index typedef sized to `width`.
- One natural sub-module: `demux_slot`, a single channel's full flag plus data register with load/drain inputs. It is instantiated four times; slots 2 and 3 have load tied off when `width==1`.
- The top level holds only select decode, `ready_o` logic and the counter.

## Test plan
- Reset, then `width=2`: `valid_i=1`, `s=2`, `data_i=32'hDEADBEEF`, `ready_i=0` → after one edge, `valid_o=4'b0100`, `d2_o=32'hDEADBEEF`, `count_o=1`.
- Back-pressure: channel 1 full with `ready_i[1]=0`, offer `s=1`, `data_i=32'h11` → `ready_o=0` for 5 cycles and `d1_o` unchanged. Raise `ready_i[1]` → accepted the same cycle, and `d1_o=32'h11` after the edge.
- Pass-through: `ready_i=4'b1111`, stream 0,1,2,3 to `s=3` on 4 consecutive cycles → `ready_o` stays 1, `d3_o` shows 0,1,2,3 on consecutive cycles, `count_o=4`.
- Independence: channel 0 full and stalled, offer `s=1` `data_i=5` with `ready_i[0]=0` → accepted, `valid_o=4'b0011`, `d0_o` unchanged.
- `width=1`: drive `ready_i=4'b1100` and `s` toggling 0/1 → `valid_o[3:2]` and `d2_o`/`d3_o` remain 0 throughout.
- Preload `count_o` to 16'hFFFF via 65535 transfers, accept one more → 16'h0000. Assert `rst` mid-transfer → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_pkg : shared widths and channel-index type for the demux   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package demux_pkg;

  localparam int DATA_W    = 32;
  localparam int NCH       = 4;
  localparam int CNT_W     = 16;
  localparam int SEL_W_MAX = 2;

  // Holds any legal select code; narrower selects are zero-extended into it.
  typedef logic [SEL_W_MAX-1:0] ch_idx_t;

  function automatic int num_channels(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_if : producer/consumer handshake bundle of the demux       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface demux_if #(
  parameter int width = 1
);
  import demux_pkg::*;

  logic               valid_i;
  logic               ready_o;
  logic [width-1:0]   s;
  logic [DATA_W-1:0]  data_i;
  logic [NCH-1:0]     valid_o;
  logic [NCH-1:0]     ready_i;
  logic [DATA_W-1:0]  d0_o;
  logic [DATA_W-1:0]  d1_o;
  logic [DATA_W-1:0]  d2_o;
  logic [DATA_W-1:0]  d3_o;
  logic [CNT_W-1:0]   count_o;

  modport master (
    output valid_i, s, data_i, ready_i,
    input  ready_o, valid_o, d0_o, d1_o, d2_o, d3_o, count_o
  );

  modport slave (
    input  valid_i, s, data_i, ready_i,
    output ready_o, valid_o, d0_o, d1_o, d2_o, d3_o, count_o
  );

endinterface
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux_slot : one channel's full flag and holding register        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module demux_slot
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  // A load on the same edge as a drain wins, so the slot stays full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (drain_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/demux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | demux : registered 1-to-N demultiplexer with per-channel buffer  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module demux
  import demux_pkg::*;
#(
  parameter int width = 1
) (
  input  logic   clk,
  input  logic   rst,
  demux_if.slave bus
);

  localparam int NUSED = num_channels(width);

  ch_idx_t           sel;
  logic              ready;
  logic              accept;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    drain;
  logic [DATA_W-1:0] hold [NCH];
  logic [CNT_W-1:0]  count_d, count_q;

  always_comb begin
    sel     = ch_idx_t'(bus.s);
    ready   = !full[sel] || bus.ready_i[sel];
    accept  = bus.valid_i && ready;
    drain   = full & bus.ready_i;
    count_d = count_q + CNT_W'(accept);
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    logic load;
    // Channels beyond the select range are never loaded and so stay empty.
    if (k < NUSED) begin : g_live
      assign load = accept && (sel == ch_idx_t'(k));
    end else begin : g_tied
      assign load = 1'b0;
    end

    demux_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .drain_i (drain[k]),
      .data_i  (bus.data_i),
      .valid_o (full[k]),
      .data_o  (hold[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = full;
  assign bus.d0_o    = hold[0];
  assign bus.d1_o    = hold[1];
  assign bus.d2_o    = hold[2];
  assign bus.d3_o    = hold[3];
  assign bus.count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_demux : randomized and directed checks of demux, widths 1/2   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_demux;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_if #(.width(2)) bus2 ();
  demux_if #(.width(1)) bus1 ();

  demux #(.width(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  demux #(.width(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: four one-deep mailboxes plus an accepted-word tally.
  logic        m_valid [NCH];
  logic [31:0] m_data  [NCH];
  logic [15:0] m_count;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 32'h0;
    end
    m_count = 16'h0;
  endtask

  function automatic logic model_ready(input int s, input logic [3:0] r);
    return !m_valid[s] || r[s];
  endfunction

  task automatic model_edge(input logic v, input int s, input logic [31:0] d,
                            input logic [3:0] r);
    logic acc;
    acc = v && model_ready(s, r);
    for (int k = 0; k < NCH; k++)
      if (m_valid[k] && r[k]) m_valid[k] = 1'b0;
    if (acc) begin
      m_valid[s] = 1'b1;
      m_data[s]  = d;
      m_count    = m_count + 16'd1;
    end
  endtask

  function automatic logic [3:0] model_vec();
    return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
  endfunction

  task automatic idle_inputs();
    bus2.valid_i = 1'b0; bus2.s = 2'd0; bus2.data_i = 32'h0; bus2.ready_i = 4'h0;
    bus1.valid_i = 1'b0; bus1.s = 1'b0; bus1.data_i = 32'h0; bus1.ready_i = 4'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus2.valid_o !== 4'h0 || bus2.count_o !== 16'h0 || bus2.d0_o !== 32'h0 ||
        bus2.d1_o !== 32'h0 || bus2.d2_o !== 32'h0 || bus2.d3_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_w2: valid=%b count=%h d0=%h d3=%h, expected all zero",
                               bus2.valid_o, bus2.count_o, bus2.d0_o, bus2.d3_o); end
    n_checks++;
    if (bus1.valid_o !== 4'h0 || bus1.count_o !== 16'h0 || bus1.d2_o !== 32'h0 || bus1.d3_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_w1: valid=%b count=%h, expected all zero",
                               bus1.valid_o, bus1.count_o); end
    for (int s = 0; s < 4; s++) begin
      bus2.valid_i = 1'b1;
      bus2.s = 2'(s);
      #1;
      n_checks++;
      if (bus2.ready_o !== 1'b1)
        begin n_fail++; $display("FAIL reset_ready s=%0d: got %b expected 1", s, bus2.ready_o); end
    end
    bus2.valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_word();
    apply_reset();
    bus2.valid_i = 1'b1; bus2.s = 2'd2; bus2.data_i = 32'hDEADBEEF; bus2.ready_i = 4'h0;
    @(posedge clk); #1;
    bus2.valid_i = 1'b0;
    n_checks++;
    if (bus2.valid_o !== 4'b0100 || bus2.d2_o !== 32'hDEADBEEF || bus2.count_o !== 16'd1)
      begin n_fail++; $display("FAIL first_word: valid=%b d2=%h count=%h expected 0100 deadbeef 0001",
                               bus2.valid_o, bus2.d2_o, bus2.count_o); end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    bus2.valid_i = 1'b1; bus2.s = 2'd1; bus2.data_i = 32'hAA; bus2.ready_i = 4'h0;
    @(posedge clk); #1;
    bus2.data_i = 32'h11;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus2.ready_o !== 1'b0)
        begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b expected 0", i, bus2.ready_o); end
      @(posedge clk); #1;
      n_checks++;
      if (bus2.d1_o !== 32'hAA || bus2.valid_o !== 4'b0010)
        begin n_fail++; $display("FAIL bp_hold cycle %0d: d1=%h valid=%b expected aa 0010",
                                 i, bus2.d1_o, bus2.valid_o); end
    end
    bus2.ready_i = 4'b0010;
    #1;
    n_checks++;
    if (bus2.ready_o !== 1'b1)
      begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus2.ready_o); end
    @(posedge clk); #1;
    bus2.valid_i = 1'b0; bus2.ready_i = 4'h0;
    n_checks++;
    if (bus2.d1_o !== 32'h11 || bus2.valid_o !== 4'b0010 || bus2.count_o !== 16'd2)
      begin n_fail++; $display("FAIL bp_release: d1=%h valid=%b count=%h expected 11 0010 0002",
                               bus2.d1_o, bus2.valid_o, bus2.count_o); end
  endtask

  task automatic test_pass_through();
    apply_reset();
    bus2.ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus2.valid_i = 1'b1; bus2.s = 2'd3; bus2.data_i = 32'(i);
      #1;
      n_checks++;
      if (bus2.ready_o !== 1'b1)
        begin n_fail++; $display("FAIL pass_ready %0d: got %b expected 1", i, bus2.ready_o); end
      @(posedge clk); #1;
      n_checks++;
      if (bus2.d3_o !== 32'(i) || bus2.valid_o[3] !== 1'b1)
        begin n_fail++; $display("FAIL pass_data %0d: d3=%h v3=%b expected %h 1",
                                 i, bus2.d3_o, bus2.valid_o[3], i); end
    end
    bus2.valid_i = 1'b0;
    n_checks++;
    if (bus2.count_o !== 16'd4)
      begin n_fail++; $display("FAIL pass_count: got %h expected 0004", bus2.count_o); end
  endtask

  task automatic test_independence();
    apply_reset();
    bus2.valid_i = 1'b1; bus2.s = 2'd0; bus2.data_i = 32'h77; bus2.ready_i = 4'h0;
    @(posedge clk); #1;
    bus2.s = 2'd1; bus2.data_i = 32'h5;
    #1;
    n_checks++;
    if (bus2.ready_o !== 1'b1)
      begin n_fail++; $display("FAIL indep_ready: got %b expected 1", bus2.ready_o); end
    @(posedge clk); #1;
    bus2.valid_i = 1'b0;
    n_checks++;
    if (bus2.valid_o !== 4'b0011 || bus2.d0_o !== 32'h77 || bus2.d1_o !== 32'h5)
      begin n_fail++; $display("FAIL indep: valid=%b d0=%h d1=%h expected 0011 77 5",
                               bus2.valid_o, bus2.d0_o, bus2.d1_o); end
  endtask

  task automatic test_random_w2();
    int s_r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      s_r = int'($urandom_range(0, 3));
      bus2.valid_i = ($urandom_range(0, 3) != 0);
      bus2.s       = 2'(s_r);
      bus2.data_i  = $urandom;
      bus2.ready_i = 4'($urandom_range(0, 15));
      #1;
      n_checks++;
      if (bus2.ready_o !== model_ready(s_r, bus2.ready_i))
        begin n_fail++; $display("FAIL rand_w2_ready %0d: got %b expected %b",
                                 i, bus2.ready_o, model_ready(s_r, bus2.ready_i)); end
      model_edge(bus2.valid_i, s_r, bus2.data_i, bus2.ready_i);
      @(posedge clk); #1;
      n_checks++;
      if (bus2.valid_o !== model_vec() || bus2.count_o !== m_count ||
          bus2.d0_o !== m_data[0] || bus2.d1_o !== m_data[1] ||
          bus2.d2_o !== m_data[2] || bus2.d3_o !== m_data[3])
        begin n_fail++; $display("FAIL rand_w2_state %0d: valid=%b count=%h d0..3=%h %h %h %h expected %b %h %h %h %h %h",
                                 i, bus2.valid_o, bus2.count_o, bus2.d0_o, bus2.d1_o, bus2.d2_o, bus2.d3_o,
                                 model_vec(), m_count, m_data[0], m_data[1], m_data[2], m_data[3]); end
    end
    idle_inputs();
  endtask

  task automatic test_width1();
    int s_r;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      s_r = i % 2;
      bus1.valid_i = ($urandom_range(0, 3) != 0);
      bus1.s       = 1'(s_r);
      bus1.data_i  = $urandom;
      bus1.ready_i = 4'b1100 | 4'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (bus1.ready_o !== model_ready(s_r, bus1.ready_i))
        begin n_fail++; $display("FAIL w1_ready %0d: got %b expected %b",
                                 i, bus1.ready_o, model_ready(s_r, bus1.ready_i)); end
      model_edge(bus1.valid_i, s_r, bus1.data_i, bus1.ready_i);
      @(posedge clk); #1;
      n_checks++;
      if (bus1.valid_o[3:2] !== 2'b00 || bus1.d2_o !== 32'h0 || bus1.d3_o !== 32'h0)
        begin n_fail++; $display("FAIL w1_upper %0d: valid=%b d2=%h d3=%h expected 00 0 0",
                                 i, bus1.valid_o, bus1.d2_o, bus1.d3_o); end
      n_checks++;
      if (bus1.valid_o !== model_vec() || bus1.count_o !== m_count ||
          bus1.d0_o !== m_data[0] || bus1.d1_o !== m_data[1])
        begin n_fail++; $display("FAIL w1_state %0d: valid=%b count=%h d0=%h d1=%h expected %b %h %h %h",
                                 i, bus1.valid_o, bus1.count_o, bus1.d0_o, bus1.d1_o,
                                 model_vec(), m_count, m_data[0], m_data[1]); end
    end
    idle_inputs();
  endtask

  task automatic test_count_wrap();
    apply_reset();
    bus2.valid_i = 1'b1; bus2.s = 2'd0; bus2.data_i = 32'hC0FFEE; bus2.ready_i = 4'b1111;
    repeat (65535) @(posedge clk);
    #1;
    n_checks++;
    if (bus2.count_o !== 16'hFFFF)
      begin n_fail++; $display("FAIL count_ffff: got %h expected ffff", bus2.count_o); end
    @(posedge clk); #1;
    bus2.valid_i = 1'b0;
    n_checks++;
    if (bus2.count_o !== 16'h0000)
      begin n_fail++; $display("FAIL count_wrap: got %h expected 0000", bus2.count_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus2.valid_i = 1'b1; bus2.s = 2'd0; bus2.data_i = 32'h1; bus2.ready_i = 4'h0;
    @(posedge clk); #1;
    bus2.s = 2'd3; bus2.data_i = 32'h2;
    @(posedge clk); #1;
    bus2.s = 2'd1; bus2.data_i = 32'h3;
    n_checks++;
    if (bus2.valid_o !== 4'b1001 || bus2.count_o !== 16'd2)
      begin n_fail++; $display("FAIL pre_reset: valid=%b count=%h expected 1001 0002",
                               bus2.valid_o, bus2.count_o); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus2.valid_o !== 4'h0 || bus2.count_o !== 16'h0 || bus2.d0_o !== 32'h0 ||
        bus2.d3_o !== 32'h0 || bus2.ready_o !== 1'b1)
      begin n_fail++; $display("FAIL async_reset: valid=%b count=%h d0=%h d3=%h ready=%b expected 0 0 0 0 1",
                               bus2.valid_o, bus2.count_o, bus2.d0_o, bus2.d3_o, bus2.ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus2.valid_i = 1'b0;
    n_checks++;
    if (bus2.valid_o !== 4'b0010 || bus2.d1_o !== 32'h3 || bus2.count_o !== 16'd1)
      begin n_fail++; $display("FAIL fresh_start: valid=%b d1=%h count=%h expected 0010 3 0001",
                               bus2.valid_o, bus2.d1_o, bus2.count_o); end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_first_word();
    test_back_pressure();
    test_pass_through();
    test_independence();
    test_random_w2();
    test_width1();
    test_async_reset();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
